// File: rtl/rf_wport_arbiter.sv
// Register file write-port arbiter: pipeline writeback beats load returns and mul/div results,
// which share a round-robin slot; a pending scoreboard reports busy destinations to decode.
module rf_wport_arbiter #(
    parameter int REGNUM = 32,
    parameter int DW     = 32,
    parameter int AW     = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    input  logic          md_valid,
    input  logic [AW-1:0] md_addr,
    input  logic [DW-1:0] md_data,
    output logic          md_ready,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_addr,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    input  logic [AW-1:0] rd_addr,
    output logic          rs_busy,
    output logic          rt_busy,
    output logic          rd_busy,
    output logic          rf_we,
    output logic [AW-1:0] rf_a3,
    output logic [DW-1:0] rf_wd3
);

    typedef enum logic {
        LAST_LD,
        LAST_MD
    } last_t;

    last_t              last_q;
    last_t              last_d;
    logic [REGNUM-1:0]  pending;
    logic [REGNUM-1:0]  pending_d;
    logic [REGNUM-1:0]  set_vec;
    logic [REGNUM-1:0]  clr_vec;
    logic               wb_win;
    logic               ld_fire;
    logic               md_fire;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;

    // Register 0 never reports busy, and addresses beyond REGNUM read as idle.
    function automatic logic bit_of(input logic [REGNUM-1:0] vec, input logic [AW-1:0] a);
        logic hit;
        hit = 1'b0;
        for (int i = 1; i < REGNUM; i++) begin
            if (a == AW'(i)) begin
                hit = vec[i];
            end
        end
        return hit;
    endfunction

    assign wb_win = wb_we && (wb_addr != '0);

    always_comb begin
        ld_ready = 1'b0;
        md_ready = 1'b0;
        if (!wb_win) begin
            ld_ready = ld_valid && (!md_valid || (last_q == LAST_MD));
            md_ready = md_valid && (!ld_valid || (last_q == LAST_LD));
        end
    end

    assign ld_fire = ld_valid && ld_ready;
    assign md_fire = md_valid && md_ready;

    always_comb begin
        last_d = last_q;
        if (ld_fire) begin
            last_d = LAST_LD;
        end else if (md_fire) begin
            last_d = LAST_MD;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_q <= LAST_MD;
        end else begin
            last_q <= last_d;
        end
    end

    // Winning write; a load or mul/div result aimed at r0 is accepted but never reaches the port.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (wb_win) begin
            wr_en   = 1'b1;
            wr_addr = wb_addr;
            wr_data = wb_data;
        end else if (ld_fire) begin
            wr_en   = (ld_addr != '0);
            wr_addr = ld_addr;
            wr_data = ld_data;
        end else if (md_fire) begin
            wr_en   = (md_addr != '0);
            wr_addr = md_addr;
            wr_data = md_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rf_we  <= 1'b0;
            rf_a3  <= '0;
            rf_wd3 <= '0;
        end else begin
            rf_we <= wr_en;
            if (wr_en) begin
                rf_a3  <= wr_addr;
                rf_wd3 <= wr_data;
            end
        end
    end

    // Set is applied after clear so a same-cycle issue keeps the register pending.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int i = 1; i < REGNUM; i++) begin
            set_vec[i] = iss_valid && (iss_addr == AW'(i));
            clr_vec[i] = (ld_fire && (ld_addr == AW'(i))) || (md_fire && (md_addr == AW'(i)));
        end
        pending_d = (pending & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= pending_d;
        end
    end

    assign rs_busy = bit_of(pending, rs_addr);
    assign rt_busy = bit_of(pending, rt_addr);
    assign rd_busy = bit_of(pending, rd_addr);

    // Upstream contract: decode stalls on rd_busy, WB only targets idle registers, and
    // long-latency results only return to registers that were issued.
    a_iss_not_pending: assert property (@(posedge clock) disable iff (!reset)
        (iss_valid && (iss_addr != '0) && bit_of(pending, iss_addr)) |->
        ((ld_fire && (ld_addr == iss_addr)) || (md_fire && (md_addr == iss_addr))));

    a_wb_not_pending: assert property (@(posedge clock) disable iff (!reset)
        wb_win |-> !bit_of(pending, wb_addr));

    a_ld_was_pending: assert property (@(posedge clock) disable iff (!reset)
        (ld_fire && (ld_addr != '0)) |-> bit_of(pending, ld_addr));

    a_md_was_pending: assert property (@(posedge clock) disable iff (!reset)
        (md_fire && (md_addr != '0)) |-> bit_of(pending, md_addr));

endmodule
